alu_issue_ctrl: RTL
===================

Name: alu_issue_ctrl

Overview:
- Issue/writeback controller that drives the ALU. It is the producer of the ALU's 5-bit instruction code and operands, and the consumer of its registered result and NZCV flags.
- Accepts 16-bit Thumb data-processing encodings over a valid/ready handshake and decodes them to ALU codes.
- Reads operands from an internal 8x32 low-register file, waits out the ALU's one-clock latency, writes back Rd and latches flags.
- Sits between the instruction fetch stage and the ALU.

Parameters:
- NREGS, 8, number of register-file entries (addressed by 3-bit fields).
- DW, 32, datapath width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- instr  in  16  Thumb instruction.
- instr_valid  in  1  instr is presented.
- instr_ready  out  1  controller can accept.
- done  out  1  one-cycle pulse when the instruction retires.
- illegal  out  1  qualifies done: the encoding is unsupported.
- nzcv  out  4  last captured flags, [0]=N [1]=Z [2]=C [3]=V.
- alu_instruction  out  5  ALU opcode; 0 = idle/NOP.
- alu_num1  out  DW  ALU operand 1.
- alu_num2  out  DW  ALU operand 2.
- alu_result  in  DW  registered ALU result.
- alu_flags  in  4  registered ALU flags.
- rf_wr_en  in  1  external register load.
- rf_wr_addr  in  3  external load address.
- rf_wr_data  in  DW  external load data.
- dbg_addr  in  3  debug read address.
- dbg_data  out  DW  combinational register-file read.

Behaviour:
- Reset (async, rst_n=0): FSM to IDLE; instr_ready=1; done=0; illegal=0; nzcv=0; alu_instruction=0; alu_num1=0; alu_num2=0; all registers 0. Reset mid-operation abandons the instruction: no writeback, no done.
- States: IDLE -> ISSUE -> WB -> IDLE. instr_ready=(state==IDLE).
- Accept edge E0 (instr_valid & instr_ready): the decoded opcode and operands are registered onto the alu_* outputs; state goes to ISSUE. instr must be held stable until accepted.
- Edge E1: the ALU samples its inputs; alu_instruction returns to 0; state goes to WB.
- Edge E2: alu_result is written to Rd (if the op writes back); alu_flags are captured into nzcv (if the op sets flags); done=1 for one cycle; state goes to IDLE.
- Throughput is one instruction per 3 cycles; done is high in the cycle after E2.
- Decode, num1/num2 assignment:
  - 0001100 Rm Rn Rd: ADDS (code 6), num1=Rn, num2=Rm.
  - 0001101 Rm Rn Rd: SUB (code 8), num1=Rn, num2=Rm.
  - 010000 op Rm Rd, op field:
    - AND -> 1
    - EOR -> 4
    - LSL -> 11
    - LSR -> 10
    - ASR -> 12
    - ADC -> 5
    - SBC -> 7
    - ROR -> 13
    - ORR -> 2
    - CMP -> 18
    - MVN -> 3
    - MUL -> 9
  - Format-4 operands: num1=Rd, num2=Rm. Exceptions: MVN uses num1=Rm; MUL uses num1=Rm, num2=Rd.
  - 10110010 op Rm Rd, op field (num1=Rm, num2=0):
    - SXTH -> 17
    - SXTB -> 16
    - UXTH -> 15
    - UXTB -> 14
- Writeback and flags:
  - CMP: no writeback; flags captured.
  - Extends: writeback; nzcv unchanged.
  - All other ops: writeback and flag capture.
- Illegal (TST, NEG, CMN, BIC, any other encoding):
  - Accepted, but the FSM stays in IDLE and alu_instruction stays 0.
  - done=1 and illegal=1 in the next cycle; no register or flag change.
- External load (rf_wr_en): honoured in any state.
  - It is a separate write port; if it collides with a WB write to the same address, WB wins.
  - Operands sampled on the same edge as an external load see the pre-write value (read-before-write).
- dbg_data is combinational and reflects writes after the edge.

Optional Feature:
- Macro ALU_ISSUE_BIC_EN.
- Defined: BIC (format-4 op 1110) executes as a micro-sequence: ISSUE(MVNS num1=Rm) -> WB1 (result to internal temp, no RF/flag write) -> ISSUE2(ANDS num1=Rd, num2=temp) -> WB (writeback plus flags). done follows the 4th edge after accept.
- Undefined: BIC is illegal, and the WB1 and ISSUE2 states and the temp register do not exist.

Decomposition:
- Package alu_issue_pkg holds:
  - ALU opcode constants 1..18;
  - flag indices N=0, Z=1, C=2, V=3;
  - FSM state encoding;
  - Thumb field/opcode constants.
- Sub-module thumb_dp_decoder (combinational): instr -> {alu_code, rd, rn, rm, operand-select, wb_en, flags_en, illegal}.

Test Plan:
- rf load R1=0x0000000F, R2=0x000000F0; ADDS R0,R1,R2 (0x1888) -> alu_instruction=6 in ISSUE; R0=0x000000FF; done 3 cycles after accept; nzcv N=0 Z=0.
- SUBS R3,R1,R1 (0x1A4B) -> alu_instruction=8; R3=0; nzcv Z=1 N=0.
- CMP R1,R2 (0x4291) -> alu_instruction=18, num1=0xF, num2=0xF0; registers unchanged; nzcv N=1 Z=0.
- TST (0x4211) -> alu_instruction stays 0; done=illegal=1 one cycle after accept; registers and nzcv unchanged; instr_ready stays 1.
- R5=0x00000080; SXTB R4,R5 (0xB26C) -> R4=0xFFFFFF80, nzcv unchanged. Back-to-back instr_valid during busy -> second instruction accepted only when instr_ready=1.
- ADDS issued, rst_n pulsed low during WB -> R0=0, no done; instr_ready=1 after release.

Source files
------------

// File: rtl/alu_issue_pkg.sv
// Shared constants and types for the ALU issue/writeback controller.
// The optional BIC micro-sequence is enabled by defining ALU_ISSUE_BIC_EN.
package alu_issue_pkg;

  localparam logic [4:0] ALU_NOP  = 5'd0;
  localparam logic [4:0] ALU_AND  = 5'd1;
  localparam logic [4:0] ALU_ORR  = 5'd2;
  localparam logic [4:0] ALU_MVN  = 5'd3;
  localparam logic [4:0] ALU_EOR  = 5'd4;
  localparam logic [4:0] ALU_ADC  = 5'd5;
  localparam logic [4:0] ALU_ADDS = 5'd6;
  localparam logic [4:0] ALU_SBC  = 5'd7;
  localparam logic [4:0] ALU_SUB  = 5'd8;
  localparam logic [4:0] ALU_MUL  = 5'd9;
  localparam logic [4:0] ALU_LSR  = 5'd10;
  localparam logic [4:0] ALU_LSL  = 5'd11;
  localparam logic [4:0] ALU_ASR  = 5'd12;
  localparam logic [4:0] ALU_ROR  = 5'd13;
  localparam logic [4:0] ALU_UXTB = 5'd14;
  localparam logic [4:0] ALU_UXTH = 5'd15;
  localparam logic [4:0] ALU_SXTB = 5'd16;
  localparam logic [4:0] ALU_SXTH = 5'd17;
  localparam logic [4:0] ALU_CMP  = 5'd18;

  localparam int FLAG_N = 0;
  localparam int FLAG_Z = 1;
  localparam int FLAG_C = 2;
  localparam int FLAG_V = 3;

  localparam logic [6:0] OP_ADD_REG = 7'b0001100;
  localparam logic [6:0] OP_SUB_REG = 7'b0001101;
  localparam logic [5:0] OP_DP_FMT4 = 6'b010000;
  localparam logic [7:0] OP_EXTEND  = 8'b10110010;

  localparam logic [3:0] DP_AND = 4'h0;
  localparam logic [3:0] DP_EOR = 4'h1;
  localparam logic [3:0] DP_LSL = 4'h2;
  localparam logic [3:0] DP_LSR = 4'h3;
  localparam logic [3:0] DP_ASR = 4'h4;
  localparam logic [3:0] DP_ADC = 4'h5;
  localparam logic [3:0] DP_SBC = 4'h6;
  localparam logic [3:0] DP_ROR = 4'h7;
  localparam logic [3:0] DP_CMP = 4'hA;
  localparam logic [3:0] DP_ORR = 4'hC;
  localparam logic [3:0] DP_MUL = 4'hD;
`ifdef ALU_ISSUE_BIC_EN
  localparam logic [3:0] DP_BIC = 4'hE;
`endif
  localparam logic [3:0] DP_MVN = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ISSUE  = 3'd1,
    ST_WB     = 3'd2
`ifdef ALU_ISSUE_BIC_EN
    ,
    ST_WB1    = 3'd3,
    ST_ISSUE2 = 3'd4
`endif
  } state_t;

  typedef enum logic [2:0] {
    SEL_RN_RM   = 3'd0,
    SEL_RD_RM   = 3'd1,
    SEL_RM_RM   = 3'd2,
    SEL_RM_RD   = 3'd3,
    SEL_RM_ZERO = 3'd4
  } opsel_t;

  typedef struct packed {
    logic [4:0] alu_code;
    logic [2:0] rd;
    logic [2:0] rn;
    logic [2:0] rm;
    opsel_t     sel;
    logic       wb_en;
    logic       flags_en;
    logic       illegal;
`ifdef ALU_ISSUE_BIC_EN
    logic       bic;
`endif
  } dec_t;

endpackage

// File: rtl/thumb_dp_decoder.sv
// Combinational decode of the supported Thumb data-processing encodings
// into ALU code, register fields, operand selection and retire controls.
module thumb_dp_decoder
  import alu_issue_pkg::*;
(
  input  logic [15:0] instr,
  output dec_t        dec
);

  always_comb begin
    dec          = '0;
    dec.illegal  = 1'b1;
    dec.rd       = instr[2:0];
    dec.rn       = instr[5:3];
    dec.rm       = instr[8:6];
    dec.sel      = SEL_RN_RM;
    if (instr[15:9] == OP_ADD_REG || instr[15:9] == OP_SUB_REG) begin
      dec.alu_code = (instr[15:9] == OP_ADD_REG) ? ALU_ADDS : ALU_SUB;
      dec.wb_en    = 1'b1;
      dec.flags_en = 1'b1;
      dec.illegal  = 1'b0;
    end else if (instr[15:10] == OP_DP_FMT4) begin
      dec.rm       = instr[5:3];
      dec.sel      = SEL_RD_RM;
      dec.wb_en    = 1'b1;
      dec.flags_en = 1'b1;
      dec.illegal  = 1'b0;
      case (instr[9:6])
        DP_AND: dec.alu_code = ALU_AND;
        DP_EOR: dec.alu_code = ALU_EOR;
        DP_LSL: dec.alu_code = ALU_LSL;
        DP_LSR: dec.alu_code = ALU_LSR;
        DP_ASR: dec.alu_code = ALU_ASR;
        DP_ADC: dec.alu_code = ALU_ADC;
        DP_SBC: dec.alu_code = ALU_SBC;
        DP_ROR: dec.alu_code = ALU_ROR;
        DP_ORR: dec.alu_code = ALU_ORR;
        DP_CMP: begin
          dec.alu_code = ALU_CMP;
          dec.wb_en    = 1'b0;
        end
        DP_MVN: begin
          dec.alu_code = ALU_MVN;
          dec.sel      = SEL_RM_RM;
        end
        DP_MUL: begin
          dec.alu_code = ALU_MUL;
          dec.sel      = SEL_RM_RD;
        end
`ifdef ALU_ISSUE_BIC_EN
        // First step of BIC is MVN of Rm; the controller chains the AND.
        DP_BIC: begin
          dec.alu_code = ALU_MVN;
          dec.sel      = SEL_RM_RM;
          dec.bic      = 1'b1;
        end
`endif
        default: begin
          dec.wb_en    = 1'b0;
          dec.flags_en = 1'b0;
          dec.illegal  = 1'b1;
        end
      endcase
    end else if (instr[15:8] == OP_EXTEND) begin
      dec.rm       = instr[5:3];
      dec.sel      = SEL_RM_ZERO;
      dec.wb_en    = 1'b1;
      dec.illegal  = 1'b0;
      case (instr[7:6])
        2'b00:   dec.alu_code = ALU_SXTH;
        2'b01:   dec.alu_code = ALU_SXTB;
        2'b10:   dec.alu_code = ALU_UXTH;
        default: dec.alu_code = ALU_UXTB;
      endcase
    end
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue/writeback controller: decodes Thumb DP instructions, drives the ALU,
// writes back Rd and latches NZCV. BIC support is enabled by ALU_ISSUE_BIC_EN.
module alu_issue_ctrl
  import alu_issue_pkg::*;
#(
  parameter int NREGS = 8,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [15:0]   instr,
  input  logic          instr_valid,
  output logic          instr_ready,
  output logic          done,
  output logic          illegal,
  output logic [3:0]    nzcv,
  output logic [4:0]    alu_instruction,
  output logic [DW-1:0] alu_num1,
  output logic [DW-1:0] alu_num2,
  input  logic [DW-1:0] alu_result,
  input  logic [3:0]    alu_flags,
  input  logic          rf_wr_en,
  input  logic [2:0]    rf_wr_addr,
  input  logic [DW-1:0] rf_wr_data,
  input  logic [2:0]    dbg_addr,
  output logic [DW-1:0] dbg_data
);

  state_t        state;
  dec_t          dec;
  logic [DW-1:0] rf [NREGS];
  logic [2:0]    rd_q;
  logic          wb_en_q;
  logic          flags_en_q;
  logic          wb_we;
  logic [DW-1:0] num1_next;
  logic [DW-1:0] num2_next;
`ifdef ALU_ISSUE_BIC_EN
  logic          bic_q;
`endif

  thumb_dp_decoder u_decoder (
    .instr (instr),
    .dec   (dec)
  );

  assign instr_ready = (state == ST_IDLE);
  assign dbg_data    = rf[dbg_addr];
  assign wb_we       = (state == ST_WB) && wb_en_q;

  always_comb begin
    num1_next = rf[dec.rd];
    num2_next = rf[dec.rm];
    case (dec.sel)
      SEL_RN_RM:   begin num1_next = rf[dec.rn]; num2_next = rf[dec.rm]; end
      SEL_RD_RM:   begin num1_next = rf[dec.rd]; num2_next = rf[dec.rm]; end
      SEL_RM_RM:   begin num1_next = rf[dec.rm]; num2_next = rf[dec.rm]; end
      SEL_RM_RD:   begin num1_next = rf[dec.rm]; num2_next = rf[dec.rd]; end
      SEL_RM_ZERO: begin num1_next = rf[dec.rm]; num2_next = '0;         end
      default: ;
    endcase
  end

  // Writeback is ordered after the external port so it wins a collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) rf[i] <= '0;
    end else begin
      if (rf_wr_en) rf[rf_wr_addr] <= rf_wr_data;
      if (wb_we)    rf[rd_q]       <= alu_result;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= ST_IDLE;
      done            <= 1'b0;
      illegal         <= 1'b0;
      nzcv            <= '0;
      alu_instruction <= ALU_NOP;
      alu_num1        <= '0;
      alu_num2        <= '0;
      rd_q            <= '0;
      wb_en_q         <= 1'b0;
      flags_en_q      <= 1'b0;
`ifdef ALU_ISSUE_BIC_EN
      bic_q           <= 1'b0;
`endif
    end else begin
      done    <= 1'b0;
      illegal <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (instr_valid) begin
            if (dec.illegal) begin
              done    <= 1'b1;
              illegal <= 1'b1;
            end else begin
              alu_instruction <= dec.alu_code;
              alu_num1        <= num1_next;
              alu_num2        <= num2_next;
              rd_q            <= dec.rd;
              wb_en_q         <= dec.wb_en;
              flags_en_q      <= dec.flags_en;
`ifdef ALU_ISSUE_BIC_EN
              bic_q           <= dec.bic;
`endif
              state           <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          alu_instruction <= ALU_NOP;
`ifdef ALU_ISSUE_BIC_EN
          state <= bic_q ? ST_WB1 : ST_WB;
`else
          state <= ST_WB;
`endif
        end
        ST_WB: begin
          if (flags_en_q) begin
            nzcv[FLAG_N] <= alu_flags[FLAG_N];
            nzcv[FLAG_Z] <= alu_flags[FLAG_Z];
            nzcv[FLAG_C] <= alu_flags[FLAG_C];
            nzcv[FLAG_V] <= alu_flags[FLAG_V];
          end
          done  <= 1'b1;
          state <= ST_IDLE;
        end
`ifdef ALU_ISSUE_BIC_EN
        // alu_num2 itself serves as the temp holding ~Rm for the AND step.
        ST_WB1: begin
          alu_instruction <= ALU_AND;
          alu_num1        <= rf[rd_q];
          alu_num2        <= alu_result;
          bic_q           <= 1'b0;
          state           <= ST_ISSUE2;
        end
        ST_ISSUE2: begin
          alu_instruction <= ALU_NOP;
          state           <= ST_WB;
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
